pipeline_power: RTL
===================

Name: pipeline_power

Overview:
- Parametrised successor to the fixed 4-bit-in, 32-bit-out valid-only pipeline.
- Raises each input sample to a compile-time power, one multiply per stage. Depth and widths are generic.
- Adds valid/ready backpressure with bubble collapsing, a synchronous flush, a per-sample overflow flag and an occupancy count.
- Sits between a sample source and a downstream consumer in the arithmetic practice datapath.

Parameters:
- IN_W, 4, input sample width (unsigned), >=1.
- OUT_W, 32, result width, >=IN_W.
- POWER, 4, exponent and number of pipeline stages, >=2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- i_value  input  IN_W  unsigned sample.
- i_valid  input  1  sample present.
- i_ready  output  1  stage 1 can accept this cycle.
- i_flush  input  1  synchronous flush of all in-flight samples.
- o_value  output  OUT_W  i_value^POWER mod 2^OUT_W.
- o_valid  output  1  result present at stage POWER.
- o_ready  input  1  consumer accepts this cycle.
- o_overflow  output  1  true result did not fit in OUT_W (qualified by o_valid).
- o_count  output  $clog2(POWER+1)  number of valid stages (0..POWER).

Behaviour:
- Reset (async, active-high): all stage valids, bases, accumulators and overflow flags go to 0. Outputs read o_valid=0, o_value=0, o_overflow=0, o_count=0, i_ready=1.
- Stage k (1..POWER) holds: valid_k, base_k (IN_W), acc_k (OUT_W) and ovf_k.
- Invariant: acc_k = base^k mod 2^OUT_W.
- Stage 1 load: base_1 = i_value, acc_1 = zero-extended i_value, ovf_1 = 0.
- Stage k+1 load:
  - base_{k+1} = base_k.
  - acc_{k+1} = low OUT_W bits of (acc_k * base_k), computed at full OUT_W+IN_W width.
  - ovf_{k+1} = ovf_k OR (the upper IN_W bits of that product are nonzero).
- Outputs are driven directly from stage POWER: o_value = acc_POWER, o_valid = valid_POWER, o_overflow = ovf_POWER.
- Readiness chain (combinational):
  - ready_POWER = !valid_POWER | o_ready.
  - ready_k = !valid_k | ready_{k+1}.
  - i_ready = ready_1 & !i_flush.
- Transfers on each rising edge:
  - Stage k loads from stage k-1 (or from the input for k=1) when ready_k is high.
  - The new valid_k is the upstream valid, or i_valid & i_ready for k=1.
  - A stage whose ready is low holds all of its fields.
- Bubbles collapse: an empty stage always accepts even if downstream is stalled.
- Latency: a sample accepted at edge t appears on o_valid after edge t+POWER-1, provided there is no stall. Throughput is 1 sample per cycle with o_ready held high.
- Output hold: while o_valid=1 and o_ready=0, o_value and o_overflow stay stable. Stages fill until i_ready=0, which occurs once all POWER stages are valid.
- Output handshake: a result is consumed on an edge where o_valid & o_ready. The same edge may load a new result into stage POWER.
- Flush:
  - i_flush=1 at an edge clears every valid_k and accepts no input; i_ready is 0 during that cycle.
  - Data fields may keep stale values.
  - The output handshake in the flush cycle is considered not to occur, even if o_ready=1.
- o_count: registered population count of valid_1..valid_POWER. It is updated on the same edge as the valids, and goes to 0 on flush or reset.
- Reset asserted mid-stream discards all in-flight samples immediately, without waiting for a clock edge.
- An input value of 0 gives result 0 with overflow 0. An input value of 1 gives result 1.

Test Plan:
- Defaults; reset, then inputs 3,0,1,15 with o_ready=1 → o_valid=1 exactly 3 cycles after each acceptance edge. Outputs are 81, 0, 1, 50625, all with o_overflow=0, one per cycle; o_count peaks at 4.
- OUT_W=12, POWER=4; input 15 → o_value=1473, o_overflow=1. Input 7 → o_value=2401, o_overflow=0.
- Defaults; 8 back-to-back inputs with o_ready=0 → i_ready falls after 4 acceptances and o_count=4. o_value=81 holds stable while input 3 sits at the head. Raising o_ready drains 81 then the rest in order, with no loss or duplication.
- Bubbles: input at cycles 0 and 2 only, o_ready held 0 → both samples advance and pack. o_count=2 with stages 4 and 3 valid; i_ready stays 1.
- Pulse i_flush with 3 samples in flight → next cycle o_valid=0, o_count=0. An i_valid asserted in the flush cycle is dropped. A sample 5 issued after the flush emerges as 625 with normal latency.
- Assert reset asynchronously between clock edges mid-stream → o_valid, o_count and o_overflow go to 0 before the next edge. After reset deasserts, i_ready=1.

Source files
------------

// File: rtl/pipeline_power.sv
// pipeline_power: raises each unsigned input sample to the compile-time power
// POWER, one multiply per stage. The pipeline has valid/ready backpressure with
// bubble collapsing, a synchronous flush, a per-sample overflow flag and a
// registered occupancy count.
module pipeline_power #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 32,
    parameter int POWER = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [IN_W-1:0]              i_value,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic                         i_flush,
    output logic [OUT_W-1:0]             o_value,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic                         o_overflow,
    output logic [$clog2(POWER+1)-1:0]   o_count
);
    localparam int CNT_W  = $clog2(POWER+1);
    localparam int PROD_W = OUT_W + IN_W;

    // Stage k lives at index k-1; stage POWER drives the outputs.
    logic [POWER-1:0]   valid;
    logic [POWER-1:0]   valid_next;
    logic [POWER-1:0]   ready;
    logic [POWER-1:0]   ovf;
    logic [IN_W-1:0]    base [POWER];
    logic [OUT_W-1:0]   acc  [POWER];
    logic [PROD_W-1:0]  prod [POWER-1];
    logic [CNT_W-1:0]   count;

    function automatic logic [CNT_W-1:0] popcount(input logic [POWER-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POWER; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // A stage can accept when any stage from it to the tail is empty, or the
    // consumer takes the head; walking from the tail avoids a feedback vector.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        ready     = '0;
        for (int k = POWER - 1; k >= 0; k--) begin
            tail_full = tail_full & valid[k];
            ready[k]  = o_ready | ~tail_full;
        end
    end

    assign i_ready = ready[0] & ~i_flush;

    // Next valid bits: shift into every ready stage, hold the stalled ones,
    // and clear everything on flush.
    always_comb begin
        valid_next = valid;
        if (i_flush) begin
            valid_next = '0;
        end else begin
            if (ready[0]) begin
                valid_next[0] = i_valid;
            end
            for (int k = 1; k < POWER; k++) begin
                if (ready[k]) begin
                    valid_next[k] = valid[k-1];
                end
            end
        end
    end

    // Full-width products so the bits above OUT_W reveal overflow.
    always_comb begin
        for (int k = 0; k < POWER - 1; k++) begin
            prod[k] = PROD_W'(acc[k]) * PROD_W'(base[k]);
        end
    end

    // Pipeline registers: every ready stage loads from its upstream neighbour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
            ovf   <= '0;
            for (int k = 0; k < POWER; k++) begin
                base[k] <= '0;
                acc[k]  <= '0;
            end
        end else begin
            valid <= valid_next;
            count <= popcount(valid_next);
            if (ready[0]) begin
                base[0] <= i_value;
                acc[0]  <= OUT_W'(i_value);
                ovf[0]  <= 1'b0;
            end
            for (int k = 1; k < POWER; k++) begin
                if (ready[k]) begin
                    base[k] <= base[k-1];
                    acc[k]  <= prod[k-1][OUT_W-1:0];
                    ovf[k]  <= ovf[k-1] | (|prod[k-1][PROD_W-1:OUT_W]);
                end
            end
        end
    end

    assign o_value    = acc[POWER-1];
    assign o_valid    = valid[POWER-1];
    assign o_overflow = ovf[POWER-1];
    assign o_count    = count;

endmodule
